// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns a load/store from the memory-stage
// pipeline register into a single data-memory request, stalls the pipeline
// while the access is outstanding, and formats load data on completion.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [15:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        access_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic        dm_req_reg, dm_we_reg, ld_valid_reg;
    logic [15:0] dm_addr_reg;
    logic [31:0] dm_wdata_reg, ld_data_reg;
    logic [3:0]  dm_wstrb_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  lane_reg;

    logic        access, illegal, misaligned, bad, in_idle, accept;
    logic [31:0] wdata_fmt;
    logic [3:0]  wstrb_fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_fmt;
    logic        unused_addr_bits;

    // Only the low 16 address bits reach the data memory.
    assign unused_addr_bits = ^addr_in[31:16];

    // Decode the presented access: legality, alignment and acceptance.
    always_comb begin
        access     = mem_read | mem_write;
        if (mem_write)
            illegal = funct3[2] | (funct3[1:0] == 2'b11);
        else
            illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        misaligned = ((funct3[1:0] == 2'b01) & addr_in[0]) |
                     ((funct3[1:0] == 2'b10) & (addr_in[1:0] != 2'b00));
        bad        = illegal | misaligned;
        in_idle    = (state_reg == S_IDLE);
        accept     = !rst && in_idle && access && !bad;
        access_err = !rst && in_idle && access && bad;
        stall      = !rst && (accept || (state_reg == S_REQ));
    end

    // Replicate store data across lanes: byte x4, half x2, word as-is.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (funct3[1:0])
                    2'b00:   wdata_fmt[8*gi +: 8] = wdata_in[7:0];
                    2'b01:   wdata_fmt[8*gi +: 8] = wdata_in[8*(gi%2) +: 8];
                    default: wdata_fmt[8*gi +: 8] = wdata_in[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    // Byte-lane write enables for the store size and address offset.
    always_comb begin
        case (funct3[1:0])
            2'b00:   wstrb_fmt = 4'b0001 << addr_in[1:0];
            2'b01:   wstrb_fmt = addr_in[1] ? 4'b1100 : 4'b0011;
            default: wstrb_fmt = 4'b1111;
        endcase
    end

    // Extract and extend load data from the returned word using latched size/offset.
    always_comb begin
        byte_sel = dm_rdata[{lane_reg, 3'b000} +: 8];
        half_sel = lane_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (funct3_reg)
            3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  ld_fmt = {24'd0, byte_sel};
            3'b101:  ld_fmt = {16'd0, half_sel};
            default: ld_fmt = dm_rdata;
        endcase
    end

    // Next-state logic: DONE lasts one cycle so the pipeline advances exactly once.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_REQ;
            S_REQ:   if (dm_ack) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, request latching and load result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            dm_req_reg   <= 1'b0;
            dm_we_reg    <= 1'b0;
            dm_addr_reg  <= 16'd0;
            dm_wdata_reg <= 32'd0;
            dm_wstrb_reg <= 4'd0;
            funct3_reg   <= 3'd0;
            lane_reg     <= 2'd0;
            ld_data_reg  <= 32'd0;
            ld_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ld_valid_reg <= 1'b0;
            if (accept) begin
                dm_req_reg   <= 1'b1;
                dm_we_reg    <= mem_write;
                dm_addr_reg  <= {addr_in[15:2], 2'b00};
                dm_wdata_reg <= wdata_fmt;
                dm_wstrb_reg <= mem_write ? wstrb_fmt : 4'b0000;
                funct3_reg   <= funct3;
                lane_reg     <= addr_in[1:0];
            end
            if ((state_reg == S_REQ) && dm_ack) begin
                dm_req_reg <= 1'b0;
                if (!dm_we_reg) begin
                    ld_data_reg  <= ld_fmt;
                    ld_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign dm_req   = dm_req_reg;
    assign dm_we    = dm_we_reg;
    assign dm_addr  = dm_addr_reg;
    assign dm_wdata = dm_wdata_reg;
    assign dm_wstrb = dm_wstrb_reg;
    assign ld_data  = ld_data_reg;
    assign ld_valid = ld_valid_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes expected requests
// and load results; a monitor pops and compares when the DUT presents them.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr_in, wdata_in;
    logic        dm_req, dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        access_err;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr_in(addr_in), .wdata_in(wdata_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
        .access_err(access_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t        req_q[$];
    logic [31:0] ld_q[$];
    int checks = 0;
    int failures = 0;
    int issue_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compares each presented request and each load result against the queues.
    initial begin
        req_t cur;
        bit   have_cur = 0;
        logic prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (dm_req && !prev_req) begin
                issue_cnt++;
                if (req_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_issue actual=%h required=none", dm_addr);
                    have_cur = 0;
                end else begin
                    cur = req_q.pop_front();
                    have_cur = 1;
                end
            end
            if (dm_req && have_cur) begin
                chk("dm_we",    {31'd0, dm_we},    {31'd0, cur.we});
                chk("dm_addr",  {16'd0, dm_addr},  {16'd0, cur.addr});
                chk("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, cur.wstrb});
                if (cur.we) chk("dm_wdata", dm_wdata, cur.wdata);
            end
            if (!dm_req) have_cur = 0;
            if (ld_valid) begin
                if (ld_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ld_valid actual=%h required=none", ld_data);
                end else begin
                    chk("ld_data", ld_data, ld_q.pop_front());
                end
            end
            prev_req = dm_req;
        end
    end

    // Drives one access, acks after ack_wait extra REQ cycles, returns stall count.
    task automatic run_access(input string name, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_wait,
                              output int stall_cnt, output logic err_seen);
        int req_cycles = 0;
        bit done = 0;
        mem_write = wr; mem_read = !wr; funct3 = f3; addr_in = a; wdata_in = wd;
        stall_cnt = 0; err_seen = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            dm_ack = 1'b0;
            if (access_err) err_seen = 1'b1;
            if (stall) stall_cnt++;
            if (dm_req) begin
                req_cycles++;
                if (req_cycles == ack_wait + 1) begin
                    dm_ack = 1'b1;
                    dm_rdata = rd;
                end
            end
            if (!stall) done = 1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=stalled required=complete", name);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; dm_ack = 1'b0;
        $display("txn %s addr=%h stall_cycles=%0d err=%0b", name, a, stall_cnt, err_seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sc;
        logic er;
        int   i0;
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        addr_in = 32'h0000_0102; wdata_in = 32'd0; dm_ack = 1'b0; dm_rdata = 32'h0BAD_0BAD;

        // Reset: outputs cleared, stall/access_err suppressed even with a bad access present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_access_err", {31'd0, access_err}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_addr", {16'd0, dm_addr}, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;

        // LW with three REQ cycles.
        req_q.push_back('{1'b0, 16'h1004, 32'd0, 4'b0000});
        ld_q.push_back(32'hDEAD_BEEF);
        run_access("LW", 1'b0, 3'b010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 2, sc, er);
        chk("LW_stall_cycles", sc, 32'd4);

        // Sub-word loads with sign/zero extension.
        req_q.push_back('{1'b0, 16'h0010, 32'd0, 4'b0000});
        ld_q.push_back(32'hFFFF_FF80);
        run_access("LB", 1'b0, 3'b000, 32'h0000_0013, 32'd0, 32'h80FF_7F01, 0, sc, er);
        req_q.push_back('{1'b0, 16'h0010, 32'd0, 4'b0000});
        ld_q.push_back(32'h0000_0080);
        run_access("LBU", 1'b0, 3'b100, 32'h0000_0013, 32'd0, 32'h80FF_7F01, 1, sc, er);
        req_q.push_back('{1'b0, 16'h0010, 32'd0, 4'b0000});
        ld_q.push_back(32'hFFFF_80FF);
        run_access("LH", 1'b0, 3'b001, 32'h0000_0012, 32'd0, 32'h80FF_7F01, 0, sc, er);

        // SH to upper half; ld_data must keep the LH result.
        req_q.push_back('{1'b1, 16'h0204, 32'hABCD_ABCD, 4'b1100});
        run_access("SH", 1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'd0, 0, sc, er);
        chk("SH_ld_data_kept", ld_data, 32'hFFFF_80FF);

        // Misaligned and illegal accesses: error flagged, no stall, no issue.
        run_access("LW_misaligned", 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 0, sc, er);
        chk("LW_misaligned_err", {31'd0, er}, 32'd1);
        chk("LW_misaligned_stall", sc, 32'd0);
        run_access("L_f3_011", 1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0, sc, er);
        chk("L_f3_011_err", {31'd0, er}, 32'd1);
        run_access("S_f3_100", 1'b1, 3'b100, 32'h0000_0100, 32'd0, 32'd0, 0, sc, er);
        chk("S_f3_100_err", {31'd0, er}, 32'd1);
        chk("err_stall", sc, 32'd0);

        // Ack while idle is ignored.
        @(negedge clk); dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        @(negedge clk); dm_ack = 1'b0;
        chk("idle_ack_dm_req", {31'd0, dm_req}, 32'd0);
        chk("idle_ack_ld_valid", {31'd0, ld_valid}, 32'd0);
        chk("idle_ack_ld_data", ld_data, 32'hFFFF_80FF);
        $display("txn idle_ack");
        @(posedge clk); #1;

        // SB aborted by reset in its second REQ cycle, ack in the reset cycle discarded.
        req_q.push_back('{1'b1, 16'h0020, 32'h5555_5555, 4'b0010});
        mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'b000;
        addr_in = 32'h0000_0021; wdata_in = 32'h0000_0055;
        @(negedge clk);
        chk("SB_abort_idle_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("SB_abort_req1", {31'd0, dm_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h7777_7777;
        #1;
        chk("SB_abort_rst_stall", {31'd0, stall}, 32'd0);
        chk("SB_abort_rst_err", {31'd0, access_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dm_ack = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("SB_abort_dm_req", {31'd0, dm_req}, 32'd0);
        chk("SB_abort_idle", {31'd0, stall}, 32'd0);
        chk("SB_abort_ld_valid", {31'd0, ld_valid}, 32'd0);
        chk("SB_abort_ld_data", ld_data, 32'd0);
        $display("txn SB_abort addr=00000021");
        @(posedge clk); #1;

        req_q.push_back('{1'b1, 16'h0040, 32'hCAFE_F00D, 4'b1111});
        run_access("SW_after_rst", 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'd0, 0, sc, er);
        chk("SW_after_rst_stall", sc, 32'd2);

        // Back-to-back stores, each acked immediately.
        i0 = issue_cnt;
        req_q.push_back('{1'b1, 16'h0100, 32'hA5A5_A5A5, 4'b1000});
        run_access("SB_b2b", 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0, sc, er);
        chk("SB_b2b_stall", sc, 32'd2);
        chk("SB_b2b_issues", issue_cnt - i0, 32'd1);
        i0 = issue_cnt;
        req_q.push_back('{1'b1, 16'h0108, 32'h0123_4567, 4'b1111});
        run_access("SW_b2b", 1'b1, 3'b010, 32'h0000_0108, 32'h0123_4567, 32'd0, 0, sc, er);
        chk("SW_b2b_stall", sc, 32'd2);
        repeat (3) @(posedge clk);
        chk("SW_b2b_issues", issue_cnt - i0, 32'd1);

        chk("req_q_drained", req_q.size(), 32'd0);
        chk("ld_q_drained", ld_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 mem_read  in  1  memory-stage instruction is a load.
REQ-004 mem_write  in  1  memory-stage instruction is a store; wins over mem_read if both are high.
REQ-005 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use only 000/001/010.
REQ-006 addr_in  in  32  byte address (ALU result from the memory-stage pipeline register).
REQ-007 wdata_in  in  32  store data (rs2 value from the memory-stage pipeline register).
REQ-008 dm_req  out  1  data-memory request valid.
REQ-009 dm_we  out  1  request is a write.
REQ-010 dm_addr  out  16  word address = addr_in[15:2],2'b00.
REQ-011 dm_wdata  out  32  lane-aligned store data.
REQ-012 dm_wstrb  out  4  byte-lane write enables; 0 for reads.
REQ-013 dm_ack  in  1  memory completion, single cycle.
REQ-014 dm_rdata  in  32  read word; valid only in the cycle dm_ack is high.
REQ-015 stall  out  1  freezes IF..MEM pipeline registers while high.
REQ-016 ld_data  out  32  formatted load result.
REQ-017 ld_valid  out  1  one-cycle pulse marking a new ld_data.
REQ-018 access_err  out  1  misaligned access or illegal funct3; combinational.

Function
REQ-019 FSM states IDLE, REQ, DONE. IDLE->REQ on a valid access (load or store, aligned, legal funct3). REQ->DONE on dm_ack. DONE->IDLE unconditionally.
REQ-020 Alignment: H/HU/SH need addr_in[0]=0; W/SW need addr_in[1:0]=00. Illegal: funct3 011/110/111, or store funct3 above 010.
REQ-021 access_err=1 only in IDLE with an access present and REQ-020 violated; no request issued, stall=0, the instruction retires.
REQ-022 stall=1 in IDLE when a valid access is present, and for every cycle in REQ; stall=0 in DONE so the pipeline advances once, with no duplicate issue.
REQ-023 On IDLE->REQ, latch dm_addr, dm_we, dm_wdata, dm_wstrb, funct3 and addr[1:0]; dm_req=1 from the next cycle.
REQ-024 All dm_* outputs hold stable through REQ until the dm_ack cycle. dm_req=0 in IDLE and DONE.
REQ-025 Store lanes: SB wstrb=0001<<a[1:0], wdata={4{byte}}. SH wstrb=0011<<{a[1],0}, wdata={2{half}}. SW wstrb=1111, wdata=word.
REQ-026 Load extraction on the dm_ack cycle, registered into ld_data:
- byte = rdata[8*a[1:0]+:8]; half = rdata[16*a[1]+:16].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-027 ld_valid=1 in the DONE cycle of a load only. ld_data holds its value until the next load completes; stores never modify it.
REQ-028 dm_ack while not in REQ is ignored.
REQ-029 Acks may arrive in the first REQ cycle, giving minimum access latency of 2 cycles (REQ, DONE) after acceptance. Wait is unbounded.
REQ-030 Back-to-back accesses: a new access seen in IDLE after DONE is accepted normally.

Reset
REQ-031 When rst is high at posedge clk: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_wstrb=0, ld_data=0, ld_valid=0.
REQ-032 rst asserted in REQ aborts the access: dm_req=0 from the next cycle, and any dm_ack arriving in the reset cycle is discarded.
REQ-033 stall and access_err are 0 while rst is high.

Verification
REQ-034 LW addr_in=0x0000_1004, dm_ack after 3 REQ cycles, rdata=0xDEADBEEF -> dm_addr=0x1004, stall high 4 cycles, ld_data=0xDEADBEEF, ld_valid pulse in DONE.
REQ-035 LB addr_in=0x13, rdata=0x80FF_7F01 -> ld_data=0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr_in=0x12 -> 0xFFFF_80FF.
REQ-036 SH addr_in=0x0206, wdata_in=0x1234_ABCD -> dm_we=1, dm_addr=0x0204, dm_wstrb=1100, dm_wdata=0xABCD_ABCD; ld_data unchanged.
REQ-037 LW addr_in=0x0102 -> access_err=1, dm_req never asserted, stall=0.
REQ-038 rst pulsed during the second REQ cycle of an SB -> dm_req=0 the next cycle, state IDLE, and a subsequent SW completes normally.
REQ-039 Two stores back-to-back, each acked immediately -> each issued exactly once, stall pattern 1,1,0 per store.
